// File: rtl/apb_modport.sv
// APB subsystem: one master FSM bridging a simple request port
// to two zero-wait register-memory slaves selected by the address MSB.

// Zero-wait APB slave holding a small register memory.
module apb_slave #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-2:0] idx,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready
);

    localparam int DEPTH = 1 << (AW - 1);

    logic [DW-1:0] mem [DEPTH];

    // Clear on reset; commit a write at the end of its access phase.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (psel && penable && pwrite) begin
            mem[idx] <= pwdata;
        end
    end

    assign pready = psel & penable;
    assign prdata = psel ? mem[idx] : '0;

endmodule

module apb_modport #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          i_ptransfer,
    input  logic          i_pwrite,
    input  logic [AW-1:0] i_pwaddr,
    input  logic [DW-1:0] i_pwdata,
    input  logic [AW-1:0] i_praddr,
    output logic [DW-1:0] o_prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          load;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;

    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pready1;
    logic          pready2;
    logic          pready;
    logic [DW-1:0] prdata1;
    logic [DW-1:0] prdata2;

    assign pready = pready1 | pready2;

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus control outputs decoded from the current phase.
    always_comb begin
        psel1   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        unique case (state)
            IDLE: ;
            SETUP: begin
                psel1 = ~paddr[AW-1];
                psel2 = paddr[AW-1];
            end
            ACCESS: begin
                psel1   = ~paddr[AW-1];
                psel2   = paddr[AW-1];
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic; load marks every entry into SETUP.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_ptransfer) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    if (i_ptransfer) begin
                        state_nxt = SETUP;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the request only when a transfer enters SETUP.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (load) begin
            pwrite <= i_pwrite;
            paddr  <= i_pwrite ? i_pwaddr : i_praddr;
            pwdata <= i_pwdata;
        end
    end

    // Register read data when a read access completes.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            o_prdata <= '0;
        end else if (pready && !pwrite) begin
            o_prdata <= psel2 ? prdata2 : prdata1;
        end
    end

    apb_slave #(.AW(AW), .DW(DW)) u_slave1 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite),
        .idx     (paddr[AW-2:0]),
        .pwdata  (pwdata),
        .prdata  (prdata1),
        .pready  (pready1)
    );

    apb_slave #(.AW(AW), .DW(DW)) u_slave2 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel2),
        .penable (penable),
        .pwrite  (pwrite),
        .idx     (paddr[AW-2:0]),
        .pwdata  (pwdata),
        .prdata  (prdata2),
        .pready  (pready2)
    );

endmodule

// File: tb/tb_apb_modport.sv
// Directed bench for apb_modport: reset, slave isolation,
// back-to-back transfers, read-data hold and mid-access reset.
module tb_apb_modport;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          i_ptransfer = 1'b0;
    logic          i_pwrite = 1'b0;
    logic [AW-1:0] i_pwaddr = '0;
    logic [DW-1:0] i_pwdata = '0;
    logic [AW-1:0] i_praddr = '0;
    logic [DW-1:0] o_prdata;

    int n_checks = 0;
    int n_fail = 0;

    apb_modport #(.AW(AW), .DW(DW)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .i_ptransfer (i_ptransfer),
        .i_pwrite    (i_pwrite),
        .i_pwaddr    (i_pwaddr),
        .i_pwdata    (i_pwdata),
        .i_praddr    (i_praddr),
        .o_prdata    (o_prdata)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st();
        return 32'(dut.state);
    endfunction

    // Issue one request; returns after the ACCESS-ending edge (+1).
    task automatic xfer(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
        @(negedge pclk);
        i_ptransfer = 1'b1;
        i_pwrite    = wr;
        i_pwaddr    = wr ? addr : '0;
        i_praddr    = wr ? '0 : addr;
        i_pwdata    = data;
        @(posedge pclk);
        @(negedge pclk);
        i_ptransfer = 1'b0;
        @(posedge pclk);
        @(posedge pclk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] addr,
                            input logic [DW-1:0] exp);
        xfer(1'b0, addr, 8'h00);
        check(tag, 32'(o_prdata), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("rst_prdata_held", 32'(o_prdata), 32'h0);
        check("rst_state_held", st(), 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        check("rst_state_idle", st(), 32'd0);
        rd_check("rst_read_005", 9'h005, 8'h00);

        // Single write/read on slave 1 with latency check.
        xfer(1'b1, 9'h0A5, 8'h3C);
        check("wr_state_idle", st(), 32'd0);
        @(negedge pclk);
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b0;
        i_praddr    = 9'h0A5;
        @(posedge pclk);
        #1;
        check("rd_e0_state", st(), 32'd1);
        check("rd_e0_prdata", 32'(o_prdata), 32'h00);
        @(negedge pclk);
        i_ptransfer = 1'b0;
        i_praddr    = 9'h000;
        @(posedge pclk);
        #1;
        check("rd_e1_state", st(), 32'd2);
        check("rd_e1_prdata", 32'(o_prdata), 32'h00);
        @(posedge pclk);
        #1;
        check("rd_e2_prdata", 32'(o_prdata), 32'h3C);
        check("rd_e2_state", st(), 32'd0);

        // Slave isolation at the same low index.
        xfer(1'b1, 9'h010, 8'h11);
        rd_check("iso_110_empty", 9'h110, 8'h00);
        xfer(1'b1, 9'h110, 8'h22);
        rd_check("iso_read_010", 9'h010, 8'h11);
        rd_check("iso_read_110", 9'h110, 8'h22);

        // Back-to-back write then read of 0x1FF.
        @(negedge pclk);
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b1;
        i_pwaddr    = 9'h1FF;
        i_pwdata    = 8'hFF;
        @(posedge pclk);
        #1;
        check("b2b_e0_setup", st(), 32'd1);
        @(negedge pclk);
        i_pwrite    = 1'b0;
        i_pwaddr    = 9'h000;
        i_pwdata    = 8'h00;
        i_praddr    = 9'h1FF;
        @(posedge pclk);
        #1;
        check("b2b_e1_access", st(), 32'd2);
        @(posedge pclk);
        #1;
        check("b2b_e2_setup", st(), 32'd1);
        check("b2b_e2_prdata", 32'(o_prdata), 32'h22);
        @(negedge pclk);
        i_ptransfer = 1'b0;
        i_praddr    = 9'h000;
        @(posedge pclk);
        #1;
        check("b2b_e3_access", st(), 32'd2);
        @(posedge pclk);
        #1;
        check("b2b_e4_idle", st(), 32'd0);
        check("b2b_read_1ff", 32'(o_prdata), 32'hFF);
        rd_check("b2b_read_0ff", 9'h0FF, 8'h00);

        // o_prdata holds through a write and idle cycles.
        rd_check("hold_read_0a5", 9'h0A5, 8'h3C);
        xfer(1'b1, 9'h000, 8'h77);
        repeat (5) @(posedge pclk);
        #1;
        check("hold_prdata", 32'(o_prdata), 32'h3C);
        rd_check("hold_read_000", 9'h000, 8'h77);

        // Reset during ACCESS of a write aborts it.
        @(negedge pclk);
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b1;
        i_pwaddr    = 9'h020;
        i_pwdata    = 8'h99;
        @(posedge pclk);
        @(negedge pclk);
        i_ptransfer = 1'b0;
        @(posedge pclk);
        #1;
        check("mid_access_state", st(), 32'd2);
        presetn = 1'b0;
        #1;
        check("mid_rst_prdata", 32'(o_prdata), 32'h00);
        check("mid_rst_state", st(), 32'd0);
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        rd_check("mid_read_020", 9'h020, 8'h00);
        rd_check("mid_read_0a5", 9'h0A5, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_modport.md
Name: apb_modport

Overview:
- Self-contained APB subsystem: one APB master FSM bridging a simple request interface to two APB slave register memories.
- Address MSB selects the slave (0 → slave 1, 1 → slave 2).
- Write requests store data in the selected slave; read requests return slave data on o_prdata.
- Sits as the DUT behind the team's APB interface (DRV/MON clocking blocks sample on posedge pclk).

Parameters:
- AW, 9, address width; bit AW-1 = slave select, bits AW-2:0 = word index.
- DW, 8, data width of write/read data and memory words.

Ports:
- pclk  input  1  APB clock; all state changes on rising edge.
- presetn  input  1  asynchronous active-low reset.
- i_ptransfer  input  1  transfer request; high = start/continue transfers.
- i_pwrite  input  1  1 = write, 0 = read.
- i_pwaddr  input  AW  write address (used when i_pwrite=1).
- i_pwdata  input  DW  write data.
- i_praddr  input  AW  read address (used when i_pwrite=0).
- o_prdata  output  DW  read data from last completed read.

Behaviour:
- Reset: presetn is asynchronous, active-low; clock is pclk. On reset: FSM → IDLE, internal psel1/psel2/penable/pwrite = 0, latched paddr/pwdata = 0, both slave memories cleared to 0, o_prdata = 0. Reset mid-transfer aborts it; no memory write occurs.
- Master FSM states: IDLE, SETUP, ACCESS.
- IDLE: all selects and penable low. If i_ptransfer=1 at a rising edge → SETUP; else stay.
- On every transition into SETUP:
  - latch pwrite = i_pwrite; paddr = i_pwaddr if i_pwrite else i_praddr; pwdata = i_pwdata.
  - Inputs are only sampled at that edge; later changes do not affect the in-flight transfer.
- SETUP (exactly 1 cycle):
  - psel1 = ~paddr[AW-1], psel2 = paddr[AW-1]; penable = 0.
  - Always → ACCESS.
- ACCESS:
  - Selected psel held, penable = 1.
  - Slaves are zero-wait: pready = psel & penable, so ACCESS lasts exactly 1 cycle; pslverr not implemented.
  - At the ACCESS-ending edge: if i_ptransfer=1 → SETUP (back-to-back, new inputs latched); else → IDLE.
- Slave (two instances, identical):
  - Memory of 2^(AW-1) words × DW, indexed by paddr[AW-2:0].
  - Write: at the ACCESS-ending edge with psel & penable & pwrite, mem[idx] ← pwdata.
  - Read: prdata = mem[idx], combinational while selected; 0 when not selected.
- o_prdata:
  - Registered; at the ACCESS-ending edge of a read, o_prdata ← prdata of the selected slave.
  - Holds its value through writes and idle cycles until the next read completes.
- Latency: request sampled at edge E0 → SETUP for cycle E0–E1 → ACCESS for E1–E2. Write is committed / o_prdata updated at E2 (2 cycles after sampling edge). Back-to-back throughput: 1 transfer per 2 cycles.
- Read-after-write to the same address, back-to-back: the read returns the newly written value (the write is committed before the read's ACCESS).
- Only the selected slave responds; the other slave's memory is untouched. Slave 1 and slave 2 at the same low index are independent locations.
- Full address range is mapped; no error responses.

Test Plan:
- Reset: hold presetn=0 three cycles, release → o_prdata=0, FSM IDLE, read of any address (e.g. 0x005) returns 0x00.
- Single write/read slave 1: write 0x0A5 ← 0x3C, then read 0x0A5 → o_prdata=0x3C exactly 2 edges after the read request is sampled.
- Slave isolation: write 0x010 ← 0x11 and 0x110 ← 0x22; read 0x010 → 0x11, read 0x110 → 0x22.
- Back-to-back: i_ptransfer held high with write 0x1FF ← 0xFF followed by a read of 0x1FF → SETUP/ACCESS alternate with no IDLE, read returns 0xFF.
- Hold behaviour: after read → 0x3C, perform a write 0x000 ← 0x77 and 5 idle cycles → o_prdata stays 0x3C.
- Reset mid-op: assert presetn=0 during ACCESS of write 0x020 ← 0x99 → after release, read 0x020 returns 0x00 and o_prdata=0 immediately on reset assertion.
